// File: rtl/gpu_cmd_scheduler.sv
// gpu_cmd_scheduler: buffers APB-written opcode/parameter pairs and issues them one at a
// time to gpu_decoder, holding each draw command until the line engine reports done.
module gpu_cmd_scheduler #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1048575
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       cmd_valid_i,
    input  logic [3:0]                 opcode_i,
    input  logic [24:0]                parameters_i,
    input  logic                       finished_i,
    input  logic                       clear_err_i,
    output logic                       command_o,
    output logic [3:0]                 opcode_o,
    output logic [24:0]                parameters_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       busy_o,
    output logic                       overflow_o,
    output logic                       timeout_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg, count_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [3:0]     opcode_reg;
    logic [24:0]    parameters_reg;
    logic           command_reg, overflow_reg, timeout_reg;
    logic           push, pop, full, timeout_evt;

    logic [28:0]    mem [DEPTH];

    assign full = (count_reg == FULL_COUNT);
    assign push = cmd_valid_i && !full;
    assign pop  = (state_reg == IDLE) && (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // opcode_reg already holds the command being issued, so its draw bit steers ISSUE.
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        timeout_evt = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pop) state_next = ISSUE;
            end
            ISSUE: begin
                if (opcode_reg[3]) begin
                    state_next = WAIT_DONE;
                    timer_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (finished_i) begin
                    state_next = IDLE;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next  = IDLE;
                    timeout_evt = 1'b1;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage has no reset so it maps onto block RAM; the read port is the output register.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= {opcode_i, parameters_i};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            timer_reg      <= '0;
            opcode_reg     <= '0;
            parameters_reg <= '0;
            command_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            timer_reg   <= timer_next;
            command_reg <= (state_reg == ISSUE);
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
                rd_ptr_reg                     <= rd_ptr_reg + AW'(1);
                {opcode_reg, parameters_reg}   <= mem[rd_ptr_reg];
            end
            // A set event in the same cycle as a clear leaves the flag set.
            overflow_reg <= (cmd_valid_i && full) || (overflow_reg && !clear_err_i);
            timeout_reg  <= timeout_evt || (timeout_reg && !clear_err_i);
        end
    end

    assign command_o    = command_reg;
    assign opcode_o     = opcode_reg;
    assign parameters_o = parameters_reg;
    assign count_o      = count_reg;
    assign full_o       = full;
    assign busy_o       = (state_reg != IDLE) || (count_reg != '0);
    assign overflow_o   = overflow_reg;
    assign timeout_o    = timeout_reg;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Bench for gpu_cmd_scheduler: directed scenarios plus random traffic, every cycle
// compared against a timestamp-based reference model of the issue rules.
module tb_gpu_cmd_scheduler;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk;
    logic          n_rst;
    logic          cmd_valid_i;
    logic [3:0]    opcode_i;
    logic [24:0]   parameters_i;
    logic          finished_i;
    logic          clear_err_i;
    logic          command_o;
    logic [3:0]    opcode_o;
    logic [24:0]   parameters_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          busy_o;
    logic          overflow_o;
    logic          timeout_o;

    gpu_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .cmd_valid_i  (cmd_valid_i),
        .opcode_i     (opcode_i),
        .parameters_i (parameters_i),
        .finished_i   (finished_i),
        .clear_err_i  (clear_err_i),
        .command_o    (command_o),
        .opcode_o     (opcode_o),
        .parameters_o (parameters_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [24:0] prm;
    } cmd_t;

    // Reference model: a queue plus edge timestamps for when issuing may resume.
    cmd_t        q[$];
    int          cyc       = 0;
    int          pop_ok    = 0;
    int          strobe_at = -1;
    bit          waiting   = 1'b0;
    int          wait_lo   = 0;
    int          wait_hi   = 0;
    logic [3:0]  m_op      = '0;
    logic [24:0] m_prm     = '0;
    bit          m_ovf     = 1'b0;
    bit          m_tmo     = 1'b0;
    int          last_strobe = -1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [3:0] op, input logic [24:0] prm,
                        input bit fin, input bit clr, input bit rst);
        bit   can_pop;
        bit   ovf_evt;
        bit   tmo_evt;
        int   sz;
        cmd_t c;
        cmd_valid_i  = v;
        opcode_i     = op;
        parameters_i = prm;
        finished_i   = fin;
        clear_err_i  = clr;
        n_rst        = !rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            waiting   = 1'b0;
            pop_ok    = cyc + 1;
            strobe_at = -1;
            m_op      = '0;
            m_prm     = '0;
            m_ovf     = 1'b0;
            m_tmo     = 1'b0;
        end else begin
            sz      = q.size();
            can_pop = !waiting && (cyc >= pop_ok) && (sz > 0);
            ovf_evt = 1'b0;
            tmo_evt = 1'b0;
            if (waiting && cyc >= wait_lo) begin
                if (fin) begin
                    waiting = 1'b0;
                    pop_ok  = cyc + 1;
                end else if (cyc == wait_hi) begin
                    waiting = 1'b0;
                    pop_ok  = cyc + 1;
                    tmo_evt = 1'b1;
                end
            end
            if (can_pop) begin
                c         = q.pop_front();
                m_op      = c.op;
                m_prm     = c.prm;
                strobe_at = cyc + 1;
                if (c.op[3]) begin
                    waiting = 1'b1;
                    wait_lo = cyc + 2;
                    wait_hi = cyc + 1 + TIMEOUT;
                end else begin
                    pop_ok = cyc + 2;
                end
            end
            if (v) begin
                if (sz < DEPTH) q.push_back('{op: op, prm: prm});
                else            ovf_evt = 1'b1;
            end
            m_ovf = ovf_evt || (m_ovf && !clr);
            m_tmo = tmo_evt || (m_tmo && !clr);
        end
        #1;
        if (command_o === 1'b1) last_strobe = cyc;
        check("command_o",    command_o,    (cyc == strobe_at));
        check("opcode_o",     opcode_o,     m_op);
        check("parameters_o", parameters_o, m_prm);
        check("count_o",      count_o,      q.size());
        check("full_o",       full_o,       (q.size() == DEPTH));
        check("busy_o",       busy_o,       ((cyc + 1 < pop_ok) || waiting || q.size() != 0));
        check("overflow_o",   overflow_o,   m_ovf);
        check("timeout_o",    timeout_o,    m_tmo);
        check("count_le_depth", (count_o <= DEPTH), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 25'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [3:0] op, input logic [24:0] prm);
        step(1'b1, op, prm, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int push_cyc;
        int fin_cyc;
        int sent;

        cmd_valid_i = 1'b0; opcode_i = '0; parameters_i = '0;
        finished_i = 1'b0; clear_err_i = 1'b0; n_rst = 1'b0;

        // Power-up reset.
        step(1'b0, 4'h0, 25'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 25'h0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Single config command: strobe two edges after the push edge.
        push(4'h1, 25'h00ABC);
        push_cyc = cyc;
        idle(6);
        check("lat_config", last_strobe, push_cyc + 2);

        // Draw hold: the config behind the draw waits for finished_i.
        push(4'h8, 25'h1234);
        push(4'h1, 25'h0777);
        idle(8);
        step(1'b0, 4'h0, 25'h0, 1'b1, 1'b0, 1'b0);
        fin_cyc = cyc;
        idle(5);
        check("lat_after_finish", last_strobe, fin_cyc + 2);

        // Overflow: ten draw pushes with the engine stalled.
        for (int i = 0; i < 10; i++) push(4'h8 | 4'($urandom_range(0, 7)), 25'($urandom));
        idle(2);
        check("full_after_burst", full_o, 1'b1);
        step(1'b0, 4'h0, 25'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && (q.size() != 0 || waiting); i++)
            step(1'b0, 4'h0, 25'h0, (waiting && cyc + 1 >= wait_lo && $urandom_range(0, 2) == 0),
                 1'b0, 1'b0);
        idle(3);

        // Timeout with a config queued behind, then clear.
        push(4'hA, 25'h0F0F0);
        push(4'h2, 25'h00002);
        idle(TIMEOUT + 6);
        check("timeout_set", timeout_o, 1'b1);
        step(1'b0, 4'h0, 25'h0, 1'b0, 1'b1, 1'b0);

        // finished_i on the very last waiting cycle wins over the timeout.
        push(4'hB, 25'h1ABCD);
        for (int i = 0; i < TIMEOUT + 10; i++)
            step(1'b0, 4'h0, 25'h0, (waiting && cyc + 1 == wait_hi), 1'b0, 1'b0);
        check("finish_beats_timeout", timeout_o, 1'b0);

        // Wrap: 3*DEPTH config commands with random gaps and stray finished_i noise.
        sent = 0;
        for (int i = 0; i < 400 && sent < 3 * DEPTH; i++) begin
            if ($urandom_range(0, 2) != 0 && q.size() < DEPTH) begin
                step(1'b1, 4'($urandom_range(0, 7)), 25'($urandom), ($urandom_range(0, 4) == 0),
                     1'b0, 1'b0);
                sent++;
            end else begin
                step(1'b0, 4'h0, 25'h0, ($urandom_range(0, 4) == 0), 1'b0, 1'b0);
            end
        end
        idle(2 * DEPTH + 4);
        check("wrap_drained", count_o, 0);
        check("wrap_no_overflow", overflow_o, 1'b0);

        // Reset mid-traffic while a draw is waiting.
        push(4'h9, 25'h00055);
        push(4'h3, 25'h00066);
        push(4'h4, 25'h00077);
        idle(4);
        step(1'b0, 4'h0, 25'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 25'h0, 1'b1, 1'b0, 1'b1);
        check("reset_count", count_o, 0);
        check("reset_busy", busy_o, 1'b0);
        idle(3);

        // Random mix including clears, stray finishes and occasional resets.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 2) == 0), 4'($urandom), 25'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 99) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
